// File: rtl/mobilenet_layer_sequencer_if.sv
// Control bundle between the layer sequencer and the compute engine / network bench.
// The master side is the sequencer; the slave side drives start and layer_done.
interface mobilenet_layer_sequencer_if;
   logic       start;
   logic       layer_done;
   logic       layer_start;
   logic [2:0] layer_type;
   logic       stride2;
   logic       buf_sel;
   logic       done;
   logic       error;
   logic [2:0] fsm_state;
   logic [5:0] current_layer;

   modport master (
      input  start, layer_done,
      output layer_start, layer_type, stride2, buf_sel, done, error, fsm_state, current_layer
   );

   modport slave (
      output start, layer_done,
      input  layer_start, layer_type, stride2, buf_sel, done, error, fsm_state, current_layer
   );
endinterface

// File: rtl/mobilenet_layer_sequencer.sv
// MobileNetV1 layer scheduler: walks layer IDs, pulses the engine per layer,
// ping-pongs the feature bank and guards each layer with a watchdog.
module mobilenet_layer_sequencer #(
   parameter logic [5:0]  START_LAYER_ID = 6'd0,
   parameter logic [5:0]  MAX_LAYER_ID   = 6'd28,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
   input logic                          CLK,
   input logic                          RESETn,
   mobilenet_layer_sequencer_if.master  seq
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      NEXT = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   localparam logic [2:0] T_CONV1 = 3'd0;
   localparam logic [2:0] T_DW    = 3'd1;
   localparam logic [2:0] T_PW    = 3'd2;
   localparam logic [2:0] T_AVG   = 3'd3;
   localparam logic [2:0] T_FC    = 3'd4;

   // Returns {stride2, layer_type}; IDs past the FC layer fall through to FC.
   function automatic logic [3:0] decode(input logic [5:0] id);
      logic [3:0] r;
      if (id == 6'd0)
         r = {1'b1, T_CONV1};
      else if (id == 6'd27)
         r = {1'b0, T_AVG};
      else if (id >= 6'd28)
         r = {1'b0, T_FC};
      else if (id[0])
         r = {(id == 6'd3 || id == 6'd7 || id == 6'd11 || id == 6'd23), T_DW};
      else
         r = {1'b0, T_PW};
      return r;
   endfunction

   state_t      state, state_nxt;
   logic [5:0]  cur_layer, layer_nxt;
   logic        bsel, bsel_nxt;
   logic [31:0] wd, wd_nxt;
   logic        lstart_nxt;
   logic [3:0]  dec_nxt;

   logic        lstart_r;
   logic [2:0]  ltype_r;
   logic        s2_r;
   logic        done_r;
   logic        err_r;

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         state     <= IDLE;
         cur_layer <= START_LAYER_ID;
         bsel      <= 1'b0;
         wd        <= 32'd0;
         lstart_r  <= 1'b0;
         {s2_r, ltype_r} <= decode(START_LAYER_ID);
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur_layer <= layer_nxt;
         bsel      <= bsel_nxt;
         wd        <= wd_nxt;
         lstart_r  <= lstart_nxt;
         {s2_r, ltype_r} <= dec_nxt;
         done_r    <= (state_nxt == DONE);
         err_r     <= (state_nxt == ERR);
      end
   end

   always_comb begin
      state_nxt  = state;
      layer_nxt  = cur_layer;
      bsel_nxt   = bsel;
      wd_nxt     = wd;
      lstart_nxt = 1'b0;
      case (state)
         IDLE, DONE, ERR: begin
            if (seq.start) begin
               state_nxt  = RUN;
               layer_nxt  = START_LAYER_ID;
               bsel_nxt   = 1'b0;
               wd_nxt     = 32'd0;
               lstart_nxt = 1'b1;
            end
         end
         RUN: begin
            wd_nxt = wd + 32'd1;
            // Completion in the same cycle beats an expiring watchdog.
            if (seq.layer_done)
               state_nxt = NEXT;
            else if (TIMEOUT_CYCLES != 32'd0 && wd == TIMEOUT_CYCLES)
               state_nxt = ERR;
         end
         NEXT: begin
            if (cur_layer >= MAX_LAYER_ID) begin
               state_nxt = DONE;
            end else begin
               state_nxt  = RUN;
               layer_nxt  = cur_layer + 6'd1;
               bsel_nxt   = ~bsel;
               wd_nxt     = 32'd0;
               lstart_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      dec_nxt = decode(layer_nxt);
   end

   assign seq.layer_start   = lstart_r;
   assign seq.layer_type    = ltype_r;
   assign seq.stride2       = s2_r;
   assign seq.buf_sel       = bsel;
   assign seq.done          = done_r;
   assign seq.error         = err_r;
   assign seq.fsm_state     = state;
   assign seq.current_layer = cur_layer;

endmodule

// File: tb/tb_mobilenet_layer_sequencer.sv
// Directed bench for the layer sequencer: three instances with different
// layer ranges / watchdog settings, stepped one cycle at a time on the falling edge.
module tb_mobilenet_layer_sequencer;

   logic CLK;
   logic rst_a_n, rst_b_n, rst_c_n;
   int   total, bad;
   int   ncyc, pa, pb, pc;

   mobilenet_layer_sequencer_if ifa ();
   mobilenet_layer_sequencer_if ifb ();
   mobilenet_layer_sequencer_if ifc ();

   mobilenet_layer_sequencer #(.START_LAYER_ID(6'd25), .MAX_LAYER_ID(6'd28), .TIMEOUT_CYCLES(32'd0))
      u_a (.CLK(CLK), .RESETn(rst_a_n), .seq(ifa));
   mobilenet_layer_sequencer #(.START_LAYER_ID(6'd0), .MAX_LAYER_ID(6'd28), .TIMEOUT_CYCLES(32'd20))
      u_b (.CLK(CLK), .RESETn(rst_b_n), .seq(ifb));
   mobilenet_layer_sequencer #(.START_LAYER_ID(6'd7), .MAX_LAYER_ID(6'd7), .TIMEOUT_CYCLES(32'd0))
      u_c (.CLK(CLK), .RESETn(rst_c_n), .seq(ifc));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance to the next falling edge and tally engine pulses seen in that cycle.
   task automatic cyc();
      @(negedge CLK);
      ncyc++;
      pa += int'(ifa.layer_start);
      pb += int'(ifb.layer_start);
      pc += int'(ifc.layer_start);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   // Enter on a layer_start cycle of u_b; answer after d cycles; leave on the next RUN cycle.
   task automatic run_b(input int d);
      repeat (d) cyc();
      ifb.layer_done = 1'b1;
      cyc();
      ifb.layer_done = 1'b0;
      cyc();
   endtask

   logic [2:0]  type_a [4];
   logic [28:0] s2_mask;
   int          n0, pb0, t0;

   initial begin
      total = 0; bad = 0; ncyc = 0; pa = 0; pb = 0; pc = 0;
      type_a[0] = 3'd1; type_a[1] = 3'd2; type_a[2] = 3'd3; type_a[3] = 3'd4;
      s2_mask = 29'h0080_0889;   // layers 0,3,7,11,23
      rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
      ifa.start = 1'b0; ifa.layer_done = 1'b0;
      ifb.start = 1'b0; ifb.layer_done = 1'b0;
      ifc.start = 1'b0; ifc.layer_done = 1'b0;
      repeat (2) cyc();
      rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;

      // reset state
      chk("rst_state", ifa.fsm_state, 0);
      chk("rst_layer", ifa.current_layer, 25);
      chk("rst_flags", {ifa.layer_start, ifa.buf_sel, ifa.done, ifa.error}, 0);
      chk("rst_layer_b", ifb.current_layer, 0);
      cyc();
      chk("idle_hold", ifa.fsm_state, 0);

      // ---- START=25 MAX=28, engine delay 10
      pa = 0;
      ifa.start = 1'b1;
      cyc();
      ifa.start = 1'b0;
      n0 = ncyc;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("a_pulse_%0d", i), ifa.layer_start, 1);
         chk($sformatf("a_state_%0d", i), ifa.fsm_state, 1);
         chk($sformatf("a_layer_%0d", i), ifa.current_layer, 25 + i);
         chk($sformatf("a_type_%0d", i), ifa.layer_type, type_a[i]);
         chk($sformatf("a_s2_%0d", i), ifa.stride2, 0);
         chk($sformatf("a_buf_%0d", i), ifa.buf_sel, i % 2);
         repeat (10) cyc();
         ifa.layer_done = 1'b1;
         cyc();
         ifa.layer_done = 1'b0;
         chk($sformatf("a_next_%0d", i), ifa.fsm_state, 2);
         chk($sformatf("a_nodone_%0d", i), ifa.done, 0);
         cyc();
      end
      chk("a_done", ifa.done, 1);
      chk("a_done_state", ifa.fsm_state, 3);
      chk("a_done_layer", ifa.current_layer, 28);
      chk("a_latency", ncyc - n0, 48);
      chk("a_pulses", pa, 4);
      // spurious completion in DONE
      ifa.layer_done = 1'b1;
      cyc();
      ifa.layer_done = 1'b0;
      cyc();
      chk("a_spur_done_state", ifa.fsm_state, 3);
      chk("a_spur_done_pulses", pa, 4);

      // ---- START=0 MAX=28 full run, engine delay 3, stray start/layer_done
      pb = 0;
      ifb.start = 1'b1;
      cyc();
      ifb.start = 1'b0;
      for (int l = 0; l <= 28; l++) begin
         chk($sformatf("b_pulse_%0d", l), ifb.layer_start, 1);
         chk($sformatf("b_layer_%0d", l), ifb.current_layer, l);
         chk($sformatf("b_s2_%0d", l), ifb.stride2, s2_mask[l]);
         chk($sformatf("b_buf_%0d", l), ifb.buf_sel, l % 2);
         if (l == 4) ifb.start = 1'b1;
         repeat (3) cyc();
         ifb.start = 1'b0;
         ifb.layer_done = 1'b1;
         cyc();
         chk($sformatf("b_next_%0d", l), ifb.fsm_state, 2);
         if (l != 6) ifb.layer_done = 1'b0;
         cyc();
         ifb.layer_done = 1'b0;
      end
      chk("b_done", ifb.done, 1);
      chk("b_done_layer", ifb.current_layer, 28);
      chk("b_pulses", pb, 29);

      // ---- watchdog: restart from DONE, layer 2 never answers
      ifb.start = 1'b1;
      cyc();
      ifb.start = 1'b0;
      chk("w_restart_state", ifb.fsm_state, 1);
      chk("w_restart_done", ifb.done, 0);
      run_b(3);
      run_b(3);
      chk("w_layer2", ifb.current_layer, 2);
      t0 = ncyc;
      repeat (20) cyc();
      chk("w_still_run", ifb.fsm_state, 1);
      cyc();
      chk("w_err_at", ncyc - t0, 21);
      chk("w_err_state", ifb.fsm_state, 4);
      chk("w_err_flag", ifb.error, 1);
      chk("w_err_layer", ifb.current_layer, 2);
      ifb.layer_done = 1'b1;
      cyc();
      ifb.layer_done = 1'b0;
      cyc();
      chk("w_err_sticky", ifb.fsm_state, 4);
      chk("w_err_layer_frozen", ifb.current_layer, 2);
      ifb.start = 1'b1;
      cyc();
      ifb.start = 1'b0;
      chk("w_err_restart", ifb.fsm_state, 1);
      chk("w_err_clear", ifb.error, 0);
      chk("w_err_restart_layer", ifb.current_layer, 0);
      // completion landing exactly at watchdog == limit
      repeat (20) cyc();
      ifb.layer_done = 1'b1;
      cyc();
      ifb.layer_done = 1'b0;
      chk("w_edge_next", ifb.fsm_state, 2);
      chk("w_edge_noerr", ifb.error, 0);
      cyc();
      chk("w_edge_layer", ifb.current_layer, 1);
      chk("w_edge_buf", ifb.buf_sel, 1);

      // ---- reset mid-RUN on layer 5
      repeat (4) run_b(3);
      chk("r_layer5", ifb.current_layer, 5);
      cyc();
      rst_b_n = 1'b0;
      cyc();
      rst_b_n = 1'b1;
      chk("r_state", ifb.fsm_state, 0);
      chk("r_layer", ifb.current_layer, 0);
      chk("r_flags", {ifb.layer_start, ifb.buf_sel, ifb.done, ifb.error}, 0);
      pb0 = pb;
      ifb.layer_done = 1'b1;
      cyc();
      ifb.layer_done = 1'b0;
      cyc();
      chk("r_idle_spur_state", ifb.fsm_state, 0);
      chk("r_idle_spur_pulses", pb, pb0);
      ifb.start = 1'b1;
      cyc();
      ifb.start = 1'b0;
      chk("r_rerun_pulse", ifb.layer_start, 1);
      chk("r_rerun_layer", ifb.current_layer, 0);
      run_b(3);
      chk("r_rerun_layer1", ifb.current_layer, 1);
      chk("r_rerun_buf", ifb.buf_sel, 1);

      // ---- START=MAX=7 single layer
      ifc.start = 1'b1;
      cyc();
      ifc.start = 1'b0;
      chk("c_pulse", ifc.layer_start, 1);
      chk("c_layer", ifc.current_layer, 7);
      chk("c_type", ifc.layer_type, 1);
      chk("c_s2", ifc.stride2, 1);
      repeat (2) cyc();
      ifc.layer_done = 1'b1;
      cyc();
      ifc.layer_done = 1'b0;
      cyc();
      chk("c_done", ifc.done, 1);
      chk("c_pulses", pc, 1);
      ifc.start = 1'b1;
      cyc();
      ifc.start = 1'b0;
      chk("c_rerun_state", ifc.fsm_state, 1);
      chk("c_rerun_layer", ifc.current_layer, 7);
      chk("c_rerun_buf", ifc.buf_sel, 0);
      chk("c_rerun_done", ifc.done, 0);
      chk("c_rerun_pulses", pc, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mobilenet_layer_sequencer.md
Name: mobilenet_layer_sequencer

Overview:
Top-level layer scheduler for the MobileNetV1 accelerator. It walks layer IDs START_LAYER_ID..MAX_LAYER_ID (0 = Conv1, 1..26 = DW/PW pairs, 27 = AvgPool, 28 = FC). For each layer it decodes the configuration, pulses the shared compute engine and waits for its completion. It also toggles the ping-pong feature-buffer bank between layers, runs a per-layer watchdog, and exposes the fsm_state/current_layer encoding used by the network-level benches.

Parameters:
START_LAYER_ID, 6'd0, first layer executed after start
MAX_LAYER_ID, 6'd28, last layer executed; done follows its completion
TIMEOUT_CYCLES, 32'd0, per-layer watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
CLK  input  1  clock, all logic on rising edge
RESETn  input  1  synchronous active-low reset
start  input  1  begin network run; sampled only in IDLE, DONE, ERR
layer_done  input  1  engine completion pulse; sampled only in RUN
layer_start  output  1  one-cycle pulse instructing the engine to run current_layer
layer_type  output  3  0=CONV1, 1=DW, 2=PW, 3=AVG_POOL, 4=FC
stride2  output  1  current layer has stride 2
buf_sel  output  1  input feature bank; the engine writes to ~buf_sel
done  output  1  high while in DONE
error  output  1  high while in ERR (watchdog expired)
fsm_state  output  3  0=IDLE, 1=RUN, 2=NEXT, 3=DONE, 4=ERR
current_layer  output  6  layer ID being executed

Behaviour:
- Reset (RESETn=0 at a clock edge) forces: fsm_state=IDLE, current_layer=START_LAYER_ID, layer_start=0, buf_sel=0, done=0, error=0, watchdog=0. This applies in any state, including mid-run. The engine is not notified of the reset.
- All outputs are registered. layer_type and stride2 are decoded from the next value of current_layer, so they are valid in the same cycle that current_layer changes.
- Decode rules:
  - 0 → CONV1, stride2=1.
  - 27 → AVG_POOL; 28 → FC.
  - Odd 1..25 → DW; stride2=1 for 3, 7, 11, 23, else 0.
  - Even 2..26 → PW, stride2=0.
  - IDs >28 decode as FC, stride2=0.
- IDLE: start=1 at edge k. After edge k: RUN, current_layer=START_LAYER_ID, buf_sel=0, layer_start=1 for exactly that cycle.
- RUN:
  - Watchdog is cleared on RUN entry and increments each RUN cycle.
  - layer_done=1 → NEXT at the next edge.
  - If TIMEOUT_CYCLES≠0, watchdog==TIMEOUT_CYCLES and layer_done=0 → ERR. layer_done in the same cycle wins over timeout.
  - start is ignored.
- NEXT (exactly one cycle):
  - If current_layer >= MAX_LAYER_ID → DONE.
  - Otherwise → RUN with current_layer+1, buf_sel toggled, layer_start=1.
  - Using >= means START>MAX runs START only, then DONE.
- DONE: done=1 held; current_layer holds the last layer. start → same as from IDLE (restart at START, buf_sel=0, done drops).
- ERR: error=1 held; current_layer frozen at the timed-out layer. start → restart as from IDLE, error clears. Only reset or start leaves ERR.
- layer_done outside RUN is ignored; no state change and no flag.
- Per-layer period is (cycles until layer_done) + 2: done edge → NEXT → RUN.
- Total layer_start pulses per run = MAX−START+1.
- buf_sel equals (current_layer−START_LAYER_ID) mod 2.

Test Plan:
- START=25, MAX=28; engine answers layer_done 10 cycles after each layer_start → 4 pulses on layers 25,26,27,28. Expected types DW,PW,AVG_POOL,FC; buf_sel 0,1,0,1; fsm passes RUN/NEXT each layer. done=1 exactly 2 cycles after the final layer_done; total 4·12 cycles after start.
- START=0, MAX=28, engine delay 3 → 29 layer_start pulses. stride2=1 only on layers 0,3,7,11,23. done asserts; current_layer=28.
- TIMEOUT_CYCLES=20, engine never responds on layer 2 → ERR exactly 21 cycles after that layer_start; error=1, current_layer=2. layer_done exactly at watchdog==20 instead → NEXT, no error.
- Spurious layer_done in IDLE, NEXT and DONE, plus start pulses during RUN → no state, layer or pulse changes.
- Reset asserted mid-RUN on layer 5 → next cycle IDLE, current_layer=START, all flags 0. A subsequent start runs cleanly from START.
- START=MAX=7 → single layer_start with DW, stride2=1. Then DONE; a start in DONE reruns layer 7 with buf_sel=0.
